// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory responder: opcodes, byte-enable constants,
// FSM state and latched-operation encodings, plus the byte-enable shape check.
package mem_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [3:0] BE_ALL    = 4'b1111;
  localparam int         CNT_W     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } op_t;

  // A gap in the lane mask, or a full-word access off a word boundary.
  function automatic logic be_misaligned(input logic [1:0] lo, input logic [3:0] be);
    logic contig;
    case (be)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b0110, 4'b1100, 4'b0111, 4'b1110,
      4'b1111: contig = 1'b1;
      default: contig = 1'b0;
    endcase
    return !contig || ((be == BE_ALL) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// DEPTH x 32 data RAM built as four byte-lane arrays, one shared address,
// per-lane write enables and a registered read that updates only when re=1.
module data_mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic          re,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] r_lane [DEPTH];
      logic [7:0] r_q;

      always_ff @(posedge clk) begin
        if (we[gi]) r_lane[idx] <= wdata[8*gi +: 8];
        if (re)     r_q         <= r_lane[idx];
      end

      assign rdata[8*gi +: 8] = r_q;
    end
  endgenerate

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one strobe-qualified request, waits WAIT_STATES
// cycles, then commits the access and pulses valid. Optional macro: MEM_MISALIGN_ERR_EN.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [3:0]  be,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        valid,
  output logic        busy,
  output logic        err
);

  localparam int               AW       = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  state_t            r_state, w_state_next;
  logic [CNT_W-1:0]  r_cnt, w_cnt_next;
  op_t               r_op, w_in_op, w_acc_op;
  logic [AW-1:0]     r_idx, w_acc_idx;
  logic [31:0]       r_wdata, w_acc_wdata;
  logic [3:0]        r_be, w_acc_be;
  logic              r_bad, w_in_bad, w_acc_bad;
  logic              r_zero;
  logic              w_req, w_enter_resp, w_from_in, w_re;
  logic [3:0]        w_we;
  logic [31:0]       w_ram_q;
  logic              w_unused;

  assign w_req    = cs && !(rd_n && wr_n);
  assign w_unused = ^{addr[31:AW+2], addr[1:0]};

  always_comb begin
    w_in_op = WR;
    if (!rd_n && !wr_n) w_in_op = NONE;
    else if (!rd_n)     w_in_op = RD;
  end

`ifdef MEM_MISALIGN_ERR_EN
  logic r_err;

  assign w_in_bad = (w_in_op == NONE) || be_misaligned(addr[1:0], be);

  always_ff @(posedge clk) begin
    if (rst)               r_err <= 1'b0;
    else if (w_enter_resp) r_err <= w_acc_bad;
  end

  assign err = r_err && (r_state == RESP);
`else
  assign w_in_bad = (w_in_op == NONE);
  assign err      = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_enter_resp = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          if (WAIT_STATES == 0) begin
            w_state_next = RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_state_next = WAIT;
            w_cnt_next   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (r_cnt == '0) begin
          w_state_next = RESP;
          w_enter_resp = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // With zero wait states the commit edge is the accept edge, so the live inputs are used.
  assign w_from_in   = (r_state == IDLE);
  assign w_acc_op    = w_from_in ? w_in_op           : r_op;
  assign w_acc_idx   = w_from_in ? addr[AW+1:2]      : r_idx;
  assign w_acc_wdata = w_from_in ? wdata             : r_wdata;
  assign w_acc_be    = w_from_in ? be                : r_be;
  assign w_acc_bad   = w_from_in ? w_in_bad          : r_bad;

  assign w_we = (w_enter_resp && !rst && (w_acc_op == WR) && !w_acc_bad) ? w_acc_be : 4'b0000;
  assign w_re = w_enter_resp && !rst && (w_acc_op == RD) && !w_acc_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_op    <= NONE;
      r_idx   <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_bad   <= 1'b0;
      r_zero  <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_from_in && w_req) begin
        r_op    <= w_in_op;
        r_idx   <= addr[AW+1:2];
        r_wdata <= wdata;
        r_be    <= be;
        r_bad   <= w_in_bad;
      end
      // rdata is forced to zero after reset or a rejected request, until the next good load.
      if (w_enter_resp) begin
        if (w_acc_bad)            r_zero <= 1'b1;
        else if (w_acc_op == RD)  r_zero <= 1'b0;
      end
    end
  end

  data_mem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (w_we),
    .re    (w_re),
    .idx   (w_acc_idx),
    .wdata (w_acc_wdata),
    .rdata (w_ram_q)
  );

  assign rdata = r_zero ? 32'h0 : w_ram_q;
  assign valid = (r_state == RESP);
  assign busy  = (r_state != IDLE);

endmodule
